// File: rtl/ax_monitor_pkg.sv
// Shared definitions for the approximate-adder error monitor: FSM states,
// default sizing and the ED accumulator width helper.
package ax_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } mon_state_t;

  localparam int unsigned DEF_WIDTH       = 16;
  localparam int unsigned DEF_WINDOW_LOG2 = 10;

  // Sum of 2^wl2 EDs, each at most w+1 bits wide, never overflows this width.
  function automatic int unsigned acc_width(input int unsigned w, input int unsigned wl2);
    return w + 1 + wl2;
  endfunction

endpackage

// File: rtl/ax_error_monitor_if.sv
// Sample and result handshake bundle between an approximate-adder harness
// (master) and the error monitor (slave).
interface ax_error_monitor_if
  import ax_monitor_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned WINDOW_LOG2 = DEF_WINDOW_LOG2,
  parameter int unsigned ACC_W       = acc_width(WIDTH, WINDOW_LOG2)
);

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_a;
  logic [WIDTH-1:0]       in_b;
  logic [WIDTH:0]         in_sum;

  logic                   res_valid;
  logic                   res_ready;
  logic [WINDOW_LOG2:0]   res_err_count;
  logic [ACC_W-1:0]       res_ed_sum;
  logic [WIDTH:0]         res_ed_max;

  modport master (
    output in_valid, in_a, in_b, in_sum, res_ready,
    input  in_ready, res_valid, res_err_count, res_ed_sum, res_ed_max
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sum, res_ready,
    output in_ready, res_valid, res_err_count, res_ed_sum, res_ed_max
  );

endinterface

// File: rtl/ax_ed_calc.sv
// Combinational exact-sum and error-distance calculator for one operand pair.
// Kept free of state so other characterisation benches can reuse it.
module ax_ed_calc
  import ax_monitor_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   approx,
  output logic [WIDTH:0]   exact,
  output logic [WIDTH:0]   ed
);

  // Exact sum without carry-in; the approximate sum may be above or below it.
  assign exact = {1'b0, a} + {1'b0, b};
  assign ed    = (exact >= approx) ? (exact - approx) : (approx - exact);

endmodule

// File: rtl/ax_error_monitor.sv
// Windowed error-metric monitor: accepts 2^WINDOW_LOG2 samples, accumulates
// error count, total ED and maximum ED through a two-stage pipeline, then
// presents the result on a valid/ready handshake.
module ax_error_monitor
  import ax_monitor_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned WINDOW_LOG2 = DEF_WINDOW_LOG2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  ax_error_monitor_if.slave   bus
);

  localparam int unsigned ACC_W = acc_width(WIDTH, WINDOW_LOG2);
  localparam int unsigned CNT_W = WINDOW_LOG2 + 1;
  // Index of the final sample in a window (N-1).
  localparam logic [CNT_W-1:0] LAST_IDX = {1'b0, {WINDOW_LOG2{1'b1}}};

  mon_state_t        state_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              in_ready_reg;
  logic              busy_reg;
  logic              res_valid_reg;
  logic [CNT_W-1:0]  res_err_count_reg;
  logic [ACC_W-1:0]  res_ed_sum_reg;
  logic [WIDTH:0]    res_ed_max_reg;

  logic              s1_valid_reg;
  logic [WIDTH:0]    s1_exact_reg;
  logic [WIDTH:0]    s1_approx_reg;
  logic [WIDTH:0]    s1_ed_reg;

  logic              s2_valid_reg;
  logic [CNT_W-1:0]  err_count_reg;
  logic [ACC_W-1:0]  ed_sum_reg;
  logic [WIDTH:0]    ed_max_reg;

  logic [WIDTH:0]    exact_c;
  logic [WIDTH:0]    ed_c;
  logic              accept_c;
  logic              last_accept_c;
  logic              start_c;
  logic              err_flag_c;
  logic              pipe_empty_c;

  ax_ed_calc #(.WIDTH(WIDTH)) u_ed_calc (
    .a      (bus.in_a),
    .b      (bus.in_b),
    .approx (bus.in_sum),
    .exact  (exact_c),
    .ed     (ed_c)
  );

  assign accept_c      = bus.in_valid & in_ready_reg;
  assign last_accept_c = accept_c & (count_reg == LAST_IDX);
  assign start_c       = start & (state_reg == IDLE);
  // A non-zero ED is the same as the approximate sum differing from exact.
  assign err_flag_c    = (s1_exact_reg != s1_approx_reg);
  assign pipe_empty_c  = ~s1_valid_reg & ~s2_valid_reg;

  // Stage 1: capture exact sum, approximate sum and ED of each accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_exact_reg  <= '0;
      s1_approx_reg <= '0;
      s1_ed_reg     <= '0;
    end else begin
      s1_valid_reg <= accept_c;
      if (accept_c) begin
        s1_exact_reg  <= exact_c;
        s1_approx_reg <= bus.in_sum;
        s1_ed_reg     <= ed_c;
      end
    end
  end

  // Stage 2: fold each stage-1 result into the window accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg  <= 1'b0;
      err_count_reg <= '0;
      ed_sum_reg    <= '0;
      ed_max_reg    <= '0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      if (start_c) begin
        err_count_reg <= '0;
        ed_sum_reg    <= '0;
        ed_max_reg    <= '0;
      end else if (s1_valid_reg) begin
        err_count_reg <= err_count_reg + CNT_W'(err_flag_c);
        ed_sum_reg    <= ed_sum_reg + ACC_W'(s1_ed_reg);
        if (s1_ed_reg > ed_max_reg) begin
          ed_max_reg <= s1_ed_reg;
        end
      end
    end
  end

  // Window control FSM with registered handshake outputs and result latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      count_reg         <= '0;
      in_ready_reg      <= 1'b0;
      busy_reg          <= 1'b0;
      res_valid_reg     <= 1'b0;
      res_err_count_reg <= '0;
      res_ed_sum_reg    <= '0;
      res_ed_max_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg         <= ACCUM;
            count_reg         <= '0;
            in_ready_reg      <= 1'b1;
            busy_reg          <= 1'b1;
            res_err_count_reg <= '0;
            res_ed_sum_reg    <= '0;
            res_ed_max_reg    <= '0;
          end
        end
        ACCUM: begin
          if (accept_c) begin
            count_reg <= count_reg + 1'b1;
          end
          if (last_accept_c) begin
            state_reg    <= DRAIN;
            in_ready_reg <= 1'b0;
          end
        end
        DRAIN: begin
          // Both pipeline stages must have retired before the totals are final.
          if (pipe_empty_c) begin
            state_reg         <= REPORT;
            res_valid_reg     <= 1'b1;
            res_err_count_reg <= err_count_reg;
            res_ed_sum_reg    <= ed_sum_reg;
            res_ed_max_reg    <= ed_max_reg;
          end
        end
        REPORT: begin
          if (bus.res_ready) begin
            state_reg     <= IDLE;
            res_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy              = busy_reg;
  assign bus.in_ready      = in_ready_reg;
  assign bus.res_valid     = res_valid_reg;
  assign bus.res_err_count = res_err_count_reg;
  assign bus.res_ed_sum    = res_ed_sum_reg;
  assign bus.res_ed_max    = res_ed_max_reg;

endmodule

// File: tb/tb_ax_error_monitor.sv
// Self-checking bench for ax_error_monitor with a 4-sample window. Expected
// window results are computed from the queued samples with plain integer math.
module tb_ax_error_monitor;
  import ax_monitor_pkg::*;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned WL2   = 2;
  localparam int          NS    = 4;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;

  ax_error_monitor_if #(.WIDTH(WIDTH), .WINDOW_LOG2(WL2)) ifc ();

  ax_error_monitor #(.WIDTH(WIDTH), .WINDOW_LOG2(WL2)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [16:0] qs[$];
  int exp_cnt, exp_sum, exp_max;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [16:0] s);
    qa.push_back(a);
    qb.push_back(b);
    qs.push_back(s);
  endtask

  // Random sample: exact, near-miss above/below, or an arbitrary approximate sum.
  task automatic push_random(input int err_pct);
    logic [15:0] a, b;
    int ex, si;
    a  = 16'($urandom);
    b  = 16'($urandom);
    ex = int'(a) + int'(b);
    si = ex;
    if (int'($urandom_range(0, 99)) < err_pct) begin
      case ($urandom_range(0, 2))
        0:       si = ex + int'($urandom_range(1, 500));
        1:       si = ex - int'($urandom_range(1, 500));
        default: si = int'($urandom_range(0, 131071));
      endcase
      if (si < 0) si = 0;
      if (si > 131071) si = 131071;
    end
    push(a, b, 17'(si));
  endtask

  // Reference: error metrics straight from the definition of ED.
  function automatic void model();
    int d;
    exp_cnt = 0;
    exp_sum = 0;
    exp_max = 0;
    for (int i = 0; i < NS; i++) begin
      d = (int'(qa[i]) + int'(qb[i])) - int'(qs[i]);
      if (d < 0) d = -d;
      if (d != 0) exp_cnt++;
      exp_sum += d;
      if (d > exp_max) exp_max = d;
    end
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"}, 64'(ifc.in_ready), 64'd0);
    chk({tag, "_res_valid"}, 64'(ifc.res_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_err_count"}, 64'(ifc.res_err_count), 64'd0);
    chk({tag, "_ed_sum"}, 64'(ifc.res_ed_sum), 64'd0);
    chk({tag, "_ed_max"}, 64'(ifc.res_ed_max), 64'd0);
  endtask

  task automatic check_res(input string tag);
    chk({tag, "_err_count"}, 64'(ifc.res_err_count), 64'(exp_cnt));
    chk({tag, "_ed_sum"}, 64'(ifc.res_ed_sum), 64'(exp_sum));
    chk({tag, "_ed_max"}, 64'(ifc.res_ed_max), 64'(exp_max));
  endtask

  // Runs one window from the queued samples. mode: 0 = back-to-back,
  // 1 = alternating valid, 2 = random gaps. Always called at a negedge in IDLE.
  task automatic do_window(input string name, input int mode, input bit extra_start,
                           input int hold, input bit start_at_ack);
    int  idx, guard, lat;
    bit  ph, v, acc_now, extra_done;
    model();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_ready_rise"}, 64'(ifc.in_ready), 64'd1);
    chk({name, "_busy_on"}, 64'(busy), 64'd1);
    idx = 0; guard = 0; ph = 1'b1; extra_done = 1'b0;
    while (idx < NS && guard < 200) begin
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = ph;
      else                v = 1'($urandom_range(0, 1));
      ph = ~ph;
      ifc.in_valid = v;
      ifc.in_a   = v ? qa[idx] : 16'($urandom);
      ifc.in_b   = v ? qb[idx] : 16'($urandom);
      ifc.in_sum = v ? qs[idx] : 17'($urandom);
      if (extra_start && idx == 1 && !extra_done) begin
        start = 1'b1;
        extra_done = 1'b1;
      end else begin
        start = 1'b0;
      end
      acc_now = v && ifc.in_ready;
      @(negedge clk);
      guard++;
      if (acc_now) idx++;
    end
    start = 1'b0;
    if (idx < NS) chk({name, "_accept_timeout"}, 64'(idx), 64'(NS));
    chk({name, "_ready_drop"}, 64'(ifc.in_ready), 64'd0);
    // Spurious traffic while not ready must be ignored.
    lat = 0;
    while (ifc.res_valid !== 1'b1 && lat < 20) begin
      ifc.in_valid = 1'($urandom_range(0, 1));
      ifc.in_a   = 16'($urandom);
      ifc.in_b   = 16'($urandom);
      ifc.in_sum = 17'($urandom);
      @(negedge clk);
      lat++;
    end
    ifc.in_valid = 1'b0;
    chk({name, "_latency"}, 64'(lat), 64'd3);
    chk({name, "_res_valid"}, 64'(ifc.res_valid), 64'd1);
    check_res(name);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, "_hold_valid"}, 64'(ifc.res_valid), 64'd1);
      chk({name, "_hold_busy"}, 64'(busy), 64'd1);
      check_res({name, "_hold"});
    end
    ifc.res_ready = 1'b1;
    start = start_at_ack;
    @(negedge clk);
    ifc.res_ready = 1'b0;
    start = 1'b0;
    chk({name, "_ack_valid"}, 64'(ifc.res_valid), 64'd0);
    chk({name, "_ack_busy"}, 64'(busy), 64'd0);
    chk({name, "_ack_ready"}, 64'(ifc.in_ready), 64'd0);
    check_res({name, "_idle"});
    @(negedge clk);
    chk({name, "_idle_busy"}, 64'(busy), 64'd0);
    chk({name, "_idle_ready"}, 64'(ifc.in_ready), 64'd0);
    $display("window %s: err_count=%0d ed_sum=%0d ed_max=%0d latency=%0d",
             name, ifc.res_err_count, ifc.res_ed_sum, ifc.res_ed_max, lat);
    qa.delete();
    qb.delete();
    qs.delete();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_a = '0;
    ifc.in_b = '0;
    ifc.in_sum = '0;
    ifc.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_idle("reset");

    // All-exact window.
    push(16'h1234, 16'h0001, 17'h01235);
    push(16'hFFFF, 16'h0001, 17'h10000);
    push(16'h0000, 16'h0000, 17'h00000);
    push(16'h8000, 16'h8000, 17'h10000);
    do_window("exact", 0, 1'b0, 0, 1'b0);

    // Mixed errors, long backpressure, start coinciding with the ack.
    push(16'h00FF, 16'h0001, 17'h000FC);
    push(16'h0003, 16'h0001, 17'h00006);
    push(16'hFFFF, 16'hFFFF, 17'h1FFFE);
    push(16'h000F, 16'h0001, 17'h00010);
    do_window("errors", 0, 1'b0, 10, 1'b1);

    // Partial window discarded by reset.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_a = 16'h0100;
      ifc.in_b = 16'h0200;
      ifc.in_sum = 17'h00000;
      @(negedge clk);
    end
    ifc.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("midrst");
    @(negedge clk);
    for (int i = 0; i < NS; i++) push_random(0);
    do_window("after_rst", 0, 1'b0, 0, 1'b0);

    // Alternating bubbles with a stray start during accumulation.
    for (int i = 0; i < NS; i++) push_random(70);
    do_window("bubbles", 1, 1'b1, 2, 1'b0);

    // Randomised windows.
    for (int w = 0; w < 10; w++) begin
      for (int i = 0; i < NS; i++) push_random(60);
      do_window($sformatf("rand%0d", w), 2, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Hard stop so a wedged DUT can never hang the run.
  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finished", n_total);
    $fatal(1, "timeout");
  end

endmodule
